// File: rtl/demux_pkg.sv
// Shared constants, state encoding and helpers for the 1-to-8 byte demultiplexer.
package demux_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [NCH-1:0] FULL_MASK = 8'hFF;

  typedef enum logic {
    FILL = 1'b0,
    DONE = 1'b1
  } state_e;

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NCH'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// Single held channel register: synchronous active-low clear, load on enable.
module demux_ch_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Load new data when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  // Data register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/demux1t8_8_seq.sv
// Registered 1-to-8 byte demultiplexer with addressed/scan channel selection
// and frame completion tracking.
// Optional overwrite detection output `ovr` is enabled by DEMUX_OVR_CHECK_EN.
module demux1t8_8_seq
  import demux_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic [SEL_W-1:0] s,
  input  logic             mode,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [W-1:0]     o0,
  output logic [W-1:0]     o1,
  output logic [W-1:0]     o2,
  output logic [W-1:0]     o3,
  output logic [W-1:0]     o4,
  output logic [W-1:0]     o5,
  output logic [W-1:0]     o6,
  output logic [W-1:0]     o7,
  output logic [NCH-1:0]   we,
  output logic [SEL_W-1:0] cnt,
  output logic [NCH-1:0]   mask,
  output logic             frame_done
`ifdef DEMUX_OVR_CHECK_EN
  ,
  output logic             ovr
`endif
);

  state_e           state_d, state_q;
  logic [SEL_W-1:0] cnt_d, cnt_q;
  logic [NCH-1:0]   mask_d, mask_q;
  logic [NCH-1:0]   we_d, we_q;
  logic             ready_d, ready_q;
  logic             frame_done_d, frame_done_q;
  logic             mode_prev_d, mode_prev_q;

  logic             accept;
  logic             abort;
  logic [SEL_W-1:0] ch;
  logic [W-1:0]     o_arr [NCH];

  // Handshake, channel choice and frame-abort detection.
  always_comb begin
    accept = valid_in && ready_q;
    ch     = mode ? cnt_q : s;
    abort  = (mode != mode_prev_q) && (mask_q != '0);
  end

  // Next-state logic for the frame FSM, scan counter, mask and strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    we_d         = '0;
    mode_prev_d  = mode;

    case (state_q)
      FILL: begin
        if (accept) begin
          mask_d = mask_q | onehot(ch);
          we_d   = onehot(ch);
          if (mode) cnt_d = SEL_W'(cnt_q + SEL_W'(1));
          if (mask_d == FULL_MASK) state_d = DONE;
        end
      end
      DONE: begin
        // Bubble cycle: nothing is accepted, the frame mask is retired.
        mask_d  = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase

    // A mode switch mid-frame discards the frame after any same-edge write.
    if (abort) begin
      mask_d  = '0;
      cnt_d   = '0;
      state_d = FILL;
    end

    ready_d      = (state_d == FILL);
    frame_done_d = (state_d == DONE);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      mask_q       <= '0;
      we_q         <= '0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      mode_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      we_q         <= we_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      mode_prev_q  <= mode_prev_d;
    end
  end

  // Eight held channel registers, loaded by the one-hot write decode.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    demux_ch_reg #(.W(W)) u_ch_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (we_d[i]),
      .d     (din),
      .q     (o_arr[i])
    );
  end

`ifdef DEMUX_OVR_CHECK_EN
  logic ovr_d, ovr_q;

  // Flag an addressed write to a channel already written in this frame.
  always_comb begin
    ovr_d = accept && !mode && mask_q[s];
  end

  // Overwrite flag register, aligned with the write strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`endif

  assign ready_out  = ready_q;
  assign we         = we_q;
  assign cnt        = cnt_q;
  assign mask       = mask_q;
  assign frame_done = frame_done_q;
  assign o0 = o_arr[0];
  assign o1 = o_arr[1];
  assign o2 = o_arr[2];
  assign o3 = o_arr[3];
  assign o4 = o_arr[4];
  assign o5 = o_arr[5];
  assign o6 = o_arr[6];
  assign o7 = o_arr[7];

endmodule

// File: tb/tb_demux1t8_8_seq.sv
// Directed self-checking bench for demux1t8_8_seq.
module tb_demux1t8_8_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [2:0] s;
  logic       mode;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0] we;
  logic [2:0] cnt;
  logic [7:0] mask;
  logic       frame_done;
`ifdef DEMUX_OVR_CHECK_EN
  logic       ovr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  demux1t8_8_seq #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .s          (s),
    .mode       (mode),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .o0         (o0),
    .o1         (o1),
    .o2         (o2),
    .o3         (o3),
    .o4         (o4),
    .o5         (o5),
    .o6         (o6),
    .o7         (o7),
    .we         (we),
    .cnt        (cnt),
    .mask       (mask),
    .frame_done (frame_done)
`ifdef DEMUX_OVR_CHECK_EN
    ,
    .ovr        (ovr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [2:0] sel, input logic m);
    valid_in = v;
    din      = d;
    s        = sel;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check_o(input string tag,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3,
                         input logic [7:0] e4, input logic [7:0] e5,
                         input logic [7:0] e6, input logic [7:0] e7);
    check({tag, "_o0"}, 32'(o0), 32'(e0));
    check({tag, "_o1"}, 32'(o1), 32'(e1));
    check({tag, "_o2"}, 32'(o2), 32'(e2));
    check({tag, "_o3"}, 32'(o3), 32'(e3));
    check({tag, "_o4"}, 32'(o4), 32'(e4));
    check({tag, "_o5"}, 32'(o5), 32'(e5));
    check({tag, "_o6"}, 32'(o6), 32'(e6));
    check({tag, "_o7"}, 32'(o7), 32'(e7));
  endtask

  initial begin
    logic [7:0] mexp;
    logic [2:0] order [8];

    order[0] = 3'd7; order[1] = 3'd3; order[2] = 3'd0; order[3] = 3'd5;
    order[4] = 3'd1; order[5] = 3'd6; order[6] = 3'd2; order[7] = 3'd4;

    // Reset held two cycles with a beat offered.
    rst_n = 1'b0;
    step(1'b1, 8'h55, 3'd3, 1'b0);
    step(1'b1, 8'h55, 3'd3, 1'b0);
    check_o("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("rst_we", 32'(we), 32'h00);
    check("rst_mask", 32'(mask), 32'h00);
    check("rst_cnt", 32'(cnt), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_ready", 32'(ready_out), 32'h1);
`ifdef DEMUX_OVR_CHECK_EN
    check("rst_ovr", 32'(ovr), 32'h0);
`endif
    rst_n = 1'b1;
    step(1'b0, 8'h00, 3'd0, 1'b0);
    check("rel_ready", 32'(ready_out), 32'h1);
    check("rel_we", 32'(we), 32'h00);

    // Scan sweep 0x10..0x17.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'(8'h10 + k), 3'd0, 1'b1);
      check($sformatf("scan_we%0d", k), 32'(we), 32'(8'h01 << k));
      check($sformatf("scan_fd%0d", k), 32'(frame_done), (k == 7) ? 32'h1 : 32'h0);
    end
    check("scan_ready_done", 32'(ready_out), 32'h0);
    check("scan_mask_done", 32'(mask), 32'hFF);
    check("scan_cnt_wrap", 32'(cnt), 32'h0);
    check_o("scan", 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17);
    // Beat offered during the bubble is ignored.
    step(1'b1, 8'h20, 3'd0, 1'b1);
    check("bubble_we", 32'(we), 32'h00);
    check("bubble_o0", 32'(o0), 32'h10);
    check("bubble_fd", 32'(frame_done), 32'h0);
    check("bubble_mask", 32'(mask), 32'h00);
    check("bubble_ready", 32'(ready_out), 32'h1);
    step(1'b1, 8'h20, 3'd0, 1'b1);
    check("late_o0", 32'(o0), 32'h20);
    check("late_we", 32'(we), 32'h01);
    check("late_mask", 32'(mask), 32'h01);
    check("late_cnt", 32'(cnt), 32'h1);

    // Switch to addressed mode with mask set: frame aborted.
    step(1'b0, 8'h00, 3'd0, 1'b0);
    check("ab1_mask", 32'(mask), 32'h00);
    check("ab1_cnt", 32'(cnt), 32'h0);
    check("ab1_o0", 32'(o0), 32'h20);

    // Addressed, out of order.
    mexp = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'(8'hA0 + order[k]), order[k], 1'b0);
      mexp = mexp | (8'h01 << order[k]);
      check($sformatf("addr_we%0d", k), 32'(we), 32'(8'h01 << order[k]));
      check($sformatf("addr_mask%0d", k), 32'(mask), 32'(mexp));
      check($sformatf("addr_fd%0d", k), 32'(frame_done), (k == 7) ? 32'h1 : 32'h0);
      check($sformatf("addr_cnt%0d", k), 32'(cnt), 32'h0);
    end
    check_o("addr", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7);
    step(1'b0, 8'h00, 3'd0, 1'b0);
    check("addr_post_mask", 32'(mask), 32'h00);
    check("addr_post_fd", 32'(frame_done), 32'h0);
    check("addr_post_ready", 32'(ready_out), 32'h1);

    // Overwrite of channel 2.
    step(1'b1, 8'h11, 3'd2, 1'b0);
    check("ow1_o2", 32'(o2), 32'h11);
    check("ow1_mask", 32'(mask), 32'h04);
`ifdef DEMUX_OVR_CHECK_EN
    check("ow1_ovr", 32'(ovr), 32'h0);
`endif
    step(1'b1, 8'h22, 3'd2, 1'b0);
    check("ow2_o2", 32'(o2), 32'h22);
    check("ow2_mask", 32'(mask), 32'h04);
    check("ow2_we", 32'(we), 32'h04);
`ifdef DEMUX_OVR_CHECK_EN
    check("ow2_ovr", 32'(ovr), 32'h1);
`endif
    step(1'b0, 8'h00, 3'd2, 1'b0);
    check("ow3_we", 32'(we), 32'h00);
`ifdef DEMUX_OVR_CHECK_EN
    check("ow3_ovr", 32'(ovr), 32'h0);
`endif

    // Accept on the same edge as a mode-change abort: data lands, mask clears.
    step(1'b1, 8'h01, 3'd5, 1'b1);
    check("abacc_o0", 32'(o0), 32'h01);
    check("abacc_we", 32'(we), 32'h01);
    check("abacc_mask", 32'(mask), 32'h00);
    check("abacc_cnt", 32'(cnt), 32'h0);

    // Mode abort after three scan beats.
    step(1'b1, 8'h01, 3'd0, 1'b1);
    step(1'b1, 8'h02, 3'd0, 1'b1);
    step(1'b1, 8'h03, 3'd0, 1'b1);
    check("pre_ab_mask", 32'(mask), 32'h07);
    check("pre_ab_cnt", 32'(cnt), 32'h3);
    step(1'b0, 8'h00, 3'd0, 1'b0);
    check("ab2_mask", 32'(mask), 32'h00);
    check("ab2_cnt", 32'(cnt), 32'h0);
    check("ab2_fd", 32'(frame_done), 32'h0);
    check_o("ab2", 8'h01, 8'h02, 8'h03, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7);

    // Mid-frame reset after five scan beats.
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h30 + k), 3'd0, 1'b1);
    check("mid_mask", 32'(mask), 32'h1F);
    check("mid_cnt", 32'(cnt), 32'h5);
    rst_n = 1'b0;
    step(1'b0, 8'h00, 3'd0, 1'b1);
    rst_n = 1'b1;
    check_o("mrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("mrst_mask", 32'(mask), 32'h00);
    check("mrst_cnt", 32'(cnt), 32'h0);
    check("mrst_ready", 32'(ready_out), 32'h1);
    check("mrst_we", 32'(we), 32'h00);

    // Complete sweep after the reset.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'(8'h40 + k), 3'd0, 1'b1);
      check($sformatf("sw2_fd%0d", k), 32'(frame_done), (k == 7) ? 32'h1 : 32'h0);
    end
    check_o("sw2", 8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47);
    step(1'b0, 8'h00, 3'd0, 1'b1);
    check("sw2_post_fd", 32'(frame_done), 32'h0);
    check("sw2_post_mask", 32'(mask), 32'h00);
    check("sw2_post_cnt", 32'(cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1t8_8_seq.md
Name: demux1t8_8_seq

Overview:
- Registered 1-to-8 byte demultiplexer. It is the receive-side counterpart of the 8:1 byte mux in the ExMUX datapath.
- Accepts a stream of 8-bit beats over a valid/ready handshake. Each beat is written into one of eight held output registers.
- The destination channel comes either from an explicit select (addressed mode) or from an internal round-robin counter (scan mode).
- Signals frame completion once every channel has been written since the last frame boundary.

Parameters:
- W, 8, data width of the input beat and of each output channel.
- NCH, 8, number of channels; fixed at 8, so the select is 3 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- din  in  W  input data beat
- s  in  3  channel select; used only in addressed mode
- mode  in  1  0 = addressed (s selects), 1 = scan (internal counter selects)
- valid_in  in  1  beat present on din
- ready_out  out  1  block can accept a beat this cycle
- o0..o7  out  W each  held channel registers
- we  out  8  one-hot write strobe, registered; marks the channel written on the previous accept
- cnt  out  3  current scan index
- mask  out  8  channels written in the current frame
- frame_done  out  1  one-cycle pulse when mask reaches 8'hFF

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all of the following: o0..o7=0, we=0, cnt=0, mask=0, frame_done=0, state=FILL. ready_out=1 after reset.
- Accept: an accept occurs when valid_in && ready_out at a clk edge.
- Channel: ch = mode ? cnt : s. On accept, o[ch] is written with din; all other channels hold.
- Latency: o[ch] shows din on the edge of the accept. we[ch]=1 for that same following cycle; we=0 otherwise.
- Mask: on accept, mask[ch] is set. Rewriting an already-set channel is legal and updates the data; mask is unchanged.
- cnt advances only on an accept in scan mode: 0..7, wrapping 7->0. In addressed mode cnt holds.
- States: FILL, DONE.
- FILL -> DONE on the accept that makes mask == 8'hFF. frame_done=1 for exactly the DONE cycle.
- DONE: ready_out=0, which is the single bubble cycle. Any beat offered is ignored (it is not an accept). mask clears to 0 at exit. DONE -> FILL unconditionally next cycle. In scan mode cnt is already 0, because it wrapped.
- Mode change: a change of mode between consecutive cycles while mask != 0 aborts the frame. mask=0, cnt=0, no frame_done, and o0..o7 hold. If an accept occurs on that same edge, the accept is performed first, then the abort applies. The result is mask=0 and the data written.
- Reset mid-frame: everything returns to reset values immediately and the partial frame is discarded.
- valid_in=0: no state change except the DONE -> FILL transition.

Optional Feature:
- Macro: DEMUX_OVR_CHECK_EN.
- When defined, an extra output `ovr` (1 bit) is added. It pulses for 1 cycle, aligned with we, when an addressed-mode accept targets a channel whose mask bit is already set. ovr resets to 0.
- When not defined, the port is absent and overwrites are silent.
- Scan mode can never raise ovr.

Decomposition:
- Package demux_pkg contains:
  - NCH=8, SEL_W=3
  - state enum {FILL, DONE}
  - localparam FULL_MASK=8'hFF
- One natural sub-module, demux_ch_reg: a W-bit register with synchronous active-low clear and write enable. It is instantiated 8 times, indexed by channel.
- Top-level logic covers the FSM, counter, mask and strobes.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with valid_in=1 -> all o*=0, mask=0, cnt=0, ready_out=1 after release, no we.
- Scan sweep: mode=1, valid_in held 1, din=0x10..0x17 over 8 cycles. Expected:
  - o0..o7=0x10..0x17
  - we walks 8'h01..8'h80
  - frame_done pulses once in the 9th cycle with ready_out=0
  - a beat din=0x20 offered in that cycle is not taken
  - it lands in o0 on the 10th cycle
- Addressed out of order: mode=0, s=7,3,0,5,1,6,2,4 with din=s+0xA0 -> o_k=0xA0+k, frame_done only after the s=4 beat, mask=0 after DONE.
- Overwrite: mode=0, s=2 twice with din=0x11 then 0x22 -> o2=0x22, mask=8'h04. With DEMUX_OVR_CHECK_EN, ovr=1 on the second write only.
- Mode abort: mode=1, 3 beats (0x01,0x02,0x03), then mode toggles to 0 -> mask=0, cnt=0, o0..o2 hold 0x01..0x03, no frame_done.
- Mid-frame reset: mode=1, 5 beats, rst_n=0 for 1 cycle -> all outputs 0. A following 8-beat sweep completes normally with one frame_done.
